// File: rtl/uart_pkg.sv
// Shared UART definitions: launch-sequencer states, data width and parity helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_pkg;

  localparam int UART_DATA_W = 8;

  // Launch sequence seen by the transmitter-facing side of the TX buffer.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ACK  = 3'd2,
    DONE = 3'd3
  } tx_state_t;

  // Odd parity bit: total number of ones across data + parity is odd.
  function automatic logic odd_parity(input logic [UART_DATA_W-1:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO with show-ahead head output and an explicit occupancy counter.
// Latency: a push at cycle N is visible on dout/level at N+1; no write-to-read bypass.
// Backpressure: none internally; the caller must not push when full unless it pops in the same cycle.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset (pointers/level only)
//   push, din     : write strobe and data
//   pop           : remove head entry (caller guarantees level != 0)
//   dout          : current head entry (combinational read of storage)
//   level         : entries stored, 0..DEPTH
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int W     = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [AW:0]   level
);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;

  // Pointers wrap naturally because DEPTH == 2**AW.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is not reset; validity is tracked by level_q alone.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  // When full, a simultaneous push/pop hits the same slot: the head is read
  // here before the edge overwrites it, so the popped byte is the old one.
  assign dout  = mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer plus launch sequencer feeding the UART transmitter one byte per frame.
// Latency: write at cycle N into an empty idle buffer -> pop at edge N+1 -> tx_start high in cycle N+2.
// Backpressure: writes accepted while not full (or full with a same-cycle pop); others dropped and flagged sticky overflow.
//
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   wr_en, wr_data              : host byte write, one byte per asserted cycle
//   full, empty, level          : occupancy status decoded from the stored-entry count
//   overflow, clr_ovf           : sticky dropped-write flag and its clear (clear wins)
//   tx_busy                     : transmitter frame-in-progress flag
//   tx_start, tx_data, tx_parity: 1-cycle launch strobe, held byte and its odd parity
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [UART_DATA_W-1:0] wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [AW:0]            level,
  output logic                   overflow,
  input  logic                   clr_ovf,
  input  logic                   tx_busy,
  output logic                   tx_start,
  output logic [UART_DATA_W-1:0] tx_data,
  output logic                   tx_parity
);

  tx_state_t                state_q;
  logic                     tx_start_q;
  logic [UART_DATA_W-1:0]   tx_data_q;
  logic                     tx_parity_q;
  logic                     ovf_q, ovf_d;

  logic [UART_DATA_W-1:0]   head;
  logic [AW:0]              level_w;
  logic                     pop;
  logic                     wr_acc;

  sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (UART_DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_acc),
    .pop   (pop),
    .din   (wr_data),
    .dout  (head),
    .level (level_w)
  );

  assign full  = (level_w == (AW+1)'(DEPTH));
  assign empty = (level_w == '0);
  assign level = level_w;

  // A pop is exactly the IDLE -> LOAD transition.
  assign pop    = (state_q == IDLE) && !empty && !tx_busy;
  // A full buffer still takes a byte when the head leaves in the same cycle.
  assign wr_acc = wr_en && (!full || pop);

  always_comb begin
    ovf_d = ovf_q;
    if (clr_ovf)              ovf_d = 1'b0;
    else if (wr_en && !wr_acc) ovf_d = 1'b1;
  end

  // Launch sequencer. tx_data/tx_parity only change on a pop, so they stay
  // stable for the whole frame; tx_start is high only in the LOAD cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      tx_parity_q <= 1'b1;
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop) begin
            tx_data_q   <= head;
            tx_parity_q <= odd_parity(head);
            tx_start_q  <= 1'b1;
            state_q     <= LOAD;
          end
        end
        LOAD: state_q <= ACK;
        // Wait for the transmitter to acknowledge; a low busy here is ignored.
        ACK:  if (tx_busy)  state_q <= DONE;
        DONE: if (!tx_busy) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign tx_parity = tx_parity_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        full, empty, overflow, clr_ovf, tx_busy, tx_start, tx_parity;
  logic [AW:0] level;
  logic [7:0]  tx_data;

  uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow),
    .clr_ovf  (clr_ovf),
    .tx_busy  (tx_busy),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_parity(tx_parity)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- behavioural reference ----------------
  // Buffer = byte queue. Launch phase: 0 waiting, 1 strobe cycle,
  // 2 awaiting busy rise, 3 awaiting busy fall.
  logic [7:0] mq[$];
  int         m_phase;
  logic [7:0] m_data;
  logic       m_ovf;

  // Observed launches from the DUT.
  logic [7:0] got[$];
  logic       got_par[$];

  // Transmitter model: busy rises 3 cycles after a strobe and lasts flen_cur cycles.
  int         since;
  int         flen_cur;
  logic [7:0] pend[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_phase  = 0;
    m_data   = 8'h00;
    m_ovf    = 1'b0;
    since    = -1;
    flen_cur = 3;
  endtask

  task automatic drive(input logic we, input logic [7:0] wd, input logic bz, input logic co);
    wr_en   = we;
    wr_data = wd;
    tx_busy = bz;
    clr_ovf = co;
  endtask

  task automatic check_model();
    chk("level", 32'(level), 32'(mq.size()));
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("tx_start", 32'(tx_start), 32'(m_phase == 1));
    chk("tx_data", 32'(tx_data), 32'(m_data));
    chk("tx_parity", 32'(tx_parity), 32'(~^m_data));
    if (tx_start === 1'b1) begin
      got.push_back(tx_data);
      got_par.push_back(tx_parity);
    end
  endtask

  // Advance the reference by one cycle using the currently driven inputs, then clock.
  task automatic step();
    bit do_pop, acc;
    do_pop = (m_phase == 0) && (mq.size() > 0) && !tx_busy;
    acc    = wr_en && ((mq.size() < DEPTH) || do_pop);
    if (clr_ovf)           m_ovf = 1'b0;
    else if (wr_en && !acc) m_ovf = 1'b1;
    if (do_pop) begin
      m_data  = mq.pop_front();
      m_phase = 1;
    end else if (m_phase == 1) m_phase = 2;
    else if (m_phase == 2 && tx_busy) m_phase = 3;
    else if (m_phase == 3 && !tx_busy) m_phase = 0;
    if (acc) mq.push_back(wr_data);
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic we, input logic [7:0] wd, input logic bz, input logic co);
    drive(we, wd, bz, co);
    #3;
    check_model();
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Closed-loop run against the transmitter model. rnd=0 feeds pend[] in order
  // whenever there is room; rnd=1 uses random writes, clears and idle-busy holds.
  task automatic run_auto(input int ncyc, input int flen, input bit rnd);
    logic we, bz, co;
    logic [7:0] wd;
    for (int i = 0; i < ncyc; i++) begin
      if (since >= 0) since++;
      bz = (since >= 3) && (since < 3 + flen_cur);
      if (since >= 3 + flen_cur) since = -1;
      if (rnd && m_phase == 0 && ($urandom % 8) == 0) bz = 1'b1;
      we = 1'b0;
      wd = 8'h00;
      co = 1'b0;
      if (rnd) begin
        we = (($urandom % 5) < 2);
        wd = 8'($urandom);
        co = (($urandom % 40) == 0);
      end else if (pend.size() > 0 && mq.size() < DEPTH) begin
        we = 1'b1;
        wd = pend.pop_front();
      end
      drive(we, wd, bz, co);
      #3;
      check_model();
      if (m_phase == 1) begin
        since    = 0;
        flen_cur = rnd ? int'($urandom_range(1, 6)) : flen;
      end
      step();
    end
  endtask

  typedef struct {
    logic       we;
    logic [7:0] wd;
    logic       bz;
    logic       st;
    logic [7:0] d;
    logic       p;
    logic [4:0] lv;
    logic       em;
  } vec_t;

  vec_t tbl[6];

  initial begin
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    model_reset();

    // Test 1: single byte latency, table-driven (expected outputs within each cycle).
    tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1};
    tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 5'd1, 1'b0};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b1, 5'd0, 1'b1};
    tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1, 5'd0, 1'b1};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b1, 5'd0, 1'b1};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1, 5'd0, 1'b1};
    @(posedge clk);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].we, tbl[i].wd, tbl[i].bz, 1'b0);
      #3;
      chk($sformatf("t1[%0d].tx_start", i), 32'(tx_start), 32'(tbl[i].st));
      chk($sformatf("t1[%0d].tx_data", i), 32'(tx_data), 32'(tbl[i].d));
      chk($sformatf("t1[%0d].tx_parity", i), 32'(tx_parity), 32'(tbl[i].p));
      chk($sformatf("t1[%0d].level", i), 32'(level), 32'(tbl[i].lv));
      chk($sformatf("t1[%0d].empty", i), 32'(empty), 32'(tbl[i].em));
      check_model();
      step();
    end

    // Test 2: three back-to-back writes, ordered launches and parities.
    do_reset();
    got.delete(); got_par.delete();
    pend = '{8'h01, 8'h02, 8'h03};
    run_auto(80, 4, 1'b0);
    chk("t2.count", 32'(got.size()), 32'd3);
    if (got.size() == 3) begin
      chk("t2.d0", 32'(got[0]), 32'h01);
      chk("t2.d1", 32'(got[1]), 32'h02);
      chk("t2.d2", 32'(got[2]), 32'h03);
      chk("t2.p0", 32'(got_par[0]), 32'd0);
      chk("t2.p1", 32'(got_par[1]), 32'd0);
      chk("t2.p2", 32'(got_par[2]), 32'd1);
    end

    // Test 3: busy held high, 17 writes -> full, 17th dropped, sticky overflow.
    do_reset();
    got.delete(); got_par.delete();
    for (int i = 0; i < 17; i++) cyc(1'b1, 8'(8'h10 + i), 1'b1, 1'b0);
    chk("t3.full", 32'(full), 32'd1);
    chk("t3.level", 32'(level), 32'd16);
    chk("t3.overflow", 32'(overflow), 32'd1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t3.overflow_sticky", 32'(overflow), 32'd1);
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    chk("t3.overflow_clr", 32'(overflow), 32'd0);

    // Test 4: full buffer, busy falls, write in the pop cycle is accepted.
    cyc(1'b1, 8'hEE, 1'b0, 1'b0);
    chk("t4.level", 32'(level), 32'd16);
    chk("t4.overflow", 32'(overflow), 32'd0);
    chk("t4.tx_start", 32'(tx_start), 32'd1);
    chk("t4.tx_data", 32'(tx_data), 32'h10);
    run_auto(400, 3, 1'b0);
    chk("t4.count", 32'(got.size()), 32'd17);
    for (int i = 0; i < 17 && i < got.size(); i++)
      chk($sformatf("t4.d%0d", i), 32'(got[i]), (i < 16) ? 32'(8'h10 + i) : 32'hEE);

    // Test 5: 40 incrementing bytes through pointer wrap.
    do_reset();
    got.delete(); got_par.delete();
    for (int i = 0; i < 40; i++) pend.push_back(8'(i));
    run_auto(900, 2, 1'b0);
    chk("t5.count", 32'(got.size()), 32'd40);
    for (int i = 0; i < 40 && i < got.size(); i++)
      chk($sformatf("t5.d%0d", i), 32'(got[i]), 32'(i));

    // Test 6: reset while in DONE with 5 queued.
    do_reset();
    for (int i = 0; i < 6; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t6.state_done", 32'(dut.state_q), 32'(DONE));
    chk("t6.level5", 32'(level), 32'd5);
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    #3;
    check_model();
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    chk("t6.level", 32'(level), 32'd0);
    chk("t6.empty", 32'(empty), 32'd1);
    chk("t6.tx_start", 32'(tx_start), 32'd0);
    chk("t6.state_idle", 32'(dut.state_q), 32'(IDLE));
    chk("t6.tx_data", 32'(tx_data), 32'h00);
    got.delete(); got_par.delete();
    run_auto(20, 3, 1'b0);
    chk("t6.no_start", 32'(got.size()), 32'd0);

    // Randomized traffic against the reference.
    do_reset();
    run_auto(2500, 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
